// File: rtl/chiplet_types_pkg.sv
// chiplet_types_pkg: flit and identifier types shared by the switch and its endpoint adapters.
package chiplet_types_pkg;
    localparam int VC_COUNT = 2;
    localparam int NODE_W   = 4;
    localparam int DATA_W   = 32;

    typedef logic [$clog2(VC_COUNT)-1:0] vc_t;
    typedef logic [NODE_W-1:0]           node_id_t;

    typedef struct packed {
        node_id_t          dst;
        node_id_t          src;
        vc_t               vc;
        logic [DATA_W-1:0] payload;
    } flit_t;
endpackage

// File: rtl/switch_if.sv
// switch_if: shared switch/endpoint link bundle; every vector has one slot per switch port.
interface switch_if #(
    parameter int NUM_OUTPORTS = 4,
    parameter int NUM_BUFFERS  = 4,
    parameter int NUM_VCS      = 2
);
    import chiplet_types_pkg::*;
    flit_t                                in [NUM_OUTPORTS];
    logic [NUM_OUTPORTS-1:0]              data_ready_in;
    logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] credit_granted;
    logic [NUM_OUTPORTS-1:0]              packet_sent;
    flit_t                                out [NUM_OUTPORTS];
    logic [NUM_OUTPORTS-1:0]              data_ready_out;
    logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] buffer_available;
    logic                                 config_done;

    modport endpoint (
        output in, data_ready_in, credit_granted, packet_sent,
        input  out, data_ready_out, buffer_available, config_done
    );

    modport fabric (
        input  in, data_ready_in, credit_granted, packet_sent,
        output out, data_ready_out, buffer_available, config_done
    );
endinterface

// File: rtl/endpoint_rx_fifo.sv
// endpoint_rx_fifo: synchronous FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module endpoint_rx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: nothing is read until the pointers say it was written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/switch_endpoint_port.sv
// switch_endpoint_port: endpoint link adapter; credit-gated TX into switch input PORT, FIFO-backed RX from output PORT.
module switch_endpoint_port
    import chiplet_types_pkg::*;
#(
    parameter  int NUM_OUTPORTS = 4,
    parameter  int NUM_BUFFERS  = 4,
    parameter  int NUM_VCS      = 2,
    parameter  int PORT         = 0,
    parameter  int BUFFER_DEPTH = 8,
    parameter  int RX_DEPTH     = 8,
    localparam int CW           = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    switch_if.endpoint             sw,
    input  logic                   tx_valid,
    input  flit_t                  tx_flit,
    input  logic                   tx_last,
    output logic                   tx_ready,
    output logic                   rx_valid,
    output flit_t                  rx_flit,
    input  logic                   rx_ready,
    output logic                   rx_overflow,
    output logic [NUM_VCS*CW-1:0]  credits
);
    localparam int RAW = $clog2(RX_DEPTH);

    logic               tx_accept;
    logic [NUM_VCS-1:0] has_credit;
    flit_t              in_q;
    logic               dr_q;
    logic               ps_q;
    logic [NUM_VCS-1:0] cg_q;
    logic               rx_push;
    logic               rx_pop;
    logic               rx_full;
    logic               rx_empty;
    logic [RAW:0]       rx_count;

    assign tx_ready  = !rst && sw.config_done && has_credit[tx_flit.vc];
    assign tx_accept = tx_valid && tx_ready;

    assign sw.in[PORT]             = in_q;
    assign sw.data_ready_in[PORT]  = dr_q;
    assign sw.packet_sent[PORT]    = ps_q;
    assign sw.credit_granted[PORT] = cg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q <= '0;
            dr_q <= 1'b0;
            ps_q <= 1'b0;
        end else begin
            dr_q <= tx_accept;
            ps_q <= tx_accept && tx_last;
            if (tx_accept) in_q <= tx_flit;
        end
    end

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        logic          send;
        logic          ret;
        logic [CW-1:0] cnt;

        assign send          = tx_accept && (tx_flit.vc == vc_t'(v));
        assign ret           = sw.buffer_available[PORT][v];
        assign has_credit[v] = cnt != '0;
        assign credits[v*CW +: CW] = cnt;

        // A return that would exceed the switch buffer depth is a protocol error; the count holds.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt <= CW'(BUFFER_DEPTH);
            else if (send && !ret) cnt <= cnt - CW'(1);
            else if (ret && !send && cnt != CW'(BUFFER_DEPTH)) cnt <= cnt + CW'(1);
        end

        assert property (@(posedge clk) disable iff (rst) !(ret && !send && cnt == CW'(BUFFER_DEPTH)));
    end

    // A pop on a full FIFO frees the slot the simultaneous arrival lands in.
    assign rx_pop   = !rx_empty && rx_ready;
    assign rx_push  = sw.data_ready_out[PORT] && (!rx_full || rx_pop);
    assign rx_valid = !rx_empty;

    endpoint_rx_fifo #(
        .WIDTH ($bits(flit_t)),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (sw.out[PORT]),
        .pop   (rx_pop),
        .dout  (rx_flit),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overflow <= 1'b0;
            cg_q        <= '0;
        end else begin
            if (sw.data_ready_out[PORT] && rx_full && !rx_pop) rx_overflow <= 1'b1;
            cg_q <= rx_pop ? NUM_VCS'(1) << rx_flit.vc : '0;
        end
    end

    assert property (@(posedge clk) PORT < NUM_OUTPORTS && NUM_BUFFERS > 0);
    assert property (@(posedge clk) disable iff (rst) rx_count <= (RAW+1)'(RX_DEPTH));
endmodule
